// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB with memory timeout and retire counter.
// Optional macro MMC_ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP instead of retiring as a NOP.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [3:0]       op_code,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             reg_dest,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             mem_err,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] MEM_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ANDI = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_SLTI = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [TW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  state_e           next_fetch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      mem_cnt_q <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mem_cnt_q <= mem_cnt_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  // Every instruction boundary re-checks run, so dropping it parks the FSM in IDLE.
  assign next_fetch = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_cnt_d  = mem_cnt_q;
    mem_err_d  = mem_err_q;
    retired_d  = retired_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    reg_dest   = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        op_d = op_code;
        if (op_code <= OP_SW) begin
          state_d = S_EXEC;
        end else begin
`ifdef MMC_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d   = next_fetch;
          retired_d = retired_q + CNT_W'(1);
`endif
        end
      end
      S_EXEC: begin
        mem_cnt_d = '0;
        case (op_q)
          OP_R:    alu_op = 3'd7;
          OP_ANDI: alu_op = 3'd1;
          OP_ORI:  alu_op = 3'd2;
          OP_SLTI: alu_op = 3'd3;
          OP_BEQ,
          OP_BNE:  alu_op = 3'd4;
          default: alu_op = 3'd0;
        endcase
        alu_src = (op_q >= OP_ADDI && op_q <= OP_SLTI) || op_q == OP_LW || op_q == OP_SW;
        case (op_q)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ, OP_BNE: begin
            pc_branch = (op_q == OP_BEQ) ? alu_zero : !alu_zero;
            state_d   = next_fetch;
            retired_d = retired_q + CNT_W'(1);
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        mem_cnt_d = mem_cnt_q + TW'(1);
        // An ack on the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d   = next_fetch;
            retired_d = retired_q + CNT_W'(1);
          end
        end else if (mem_cnt_q == MEM_LAST) begin
          mem_err_d = 1'b1;
          state_d   = next_fetch;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dest   = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        state_d    = next_fetch;
        retired_d  = retired_q + CNT_W'(1);
      end
      S_TRAP: begin
`ifndef MMC_ILLEGAL_TRAP_EN
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign mem_err = mem_err_q;
  assign state   = state_q;
  assign retired = retired_q;
`ifdef MMC_ILLEGAL_TRAP_EN
  assign trap = (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instruction table plus timeout, run-drop, reset and wrap sequences.
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic [3:0]  op_code;
  logic        alu_zero;
  logic        mem_ack;

  logic        ir_write, pc_write, pc_branch, reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic [2:0]  alu_op;
  logic        busy, mem_err, trap;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        w_ir, w_pc, w_br, w_rd, w_as, w_m2r, w_rw, w_mr, w_mw, w_busy, w_err, w_trap;
  logic [2:0]  w_aop, w_state;
  logic [3:0]  w_ret;

  logic [13:0] ctl;
  assign ctl = {ir_write, pc_write, pc_branch, reg_dest, alu_src, mem_to_reg, reg_write,
                mem_read, mem_write, alu_op, busy, trap};

  always #5 clock = ~clock;

  mips_multicycle_ctrl dut (
    .clock(clock), .reset_n(reset_n), .run(run), .op_code(op_code), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .reg_dest(reg_dest), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .busy(busy),
    .mem_err(mem_err), .trap(trap), .state(state), .retired(retired)
  );

  // Narrow-counter twin driven identically, used to observe counter wrap in few cycles.
  mips_multicycle_ctrl #(.CNT_W(4)) dut_w (
    .clock(clock), .reset_n(reset_n), .run(run), .op_code(op_code), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .ir_write(w_ir), .pc_write(w_pc), .pc_branch(w_br),
    .reg_dest(w_rd), .alu_src(w_as), .mem_to_reg(w_m2r), .reg_write(w_rw),
    .mem_read(w_mr), .mem_write(w_mw), .alu_op(w_aop), .busy(w_busy),
    .mem_err(w_err), .trap(w_trap), .state(w_state), .retired(w_ret)
  );

  typedef struct {
    int op; int az; int ack; int aop; int asrc; int br; int rdst; int m2r;
    int is_mem; int is_wb; int mr; int mw; int lat;
  } vec_t;

  vec_t vecs[13];
  int   tests = 0;
  int   fails = 0;
  int   exp_ret = 0;
  int   exp_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] mk(input int ir, input int pc, input int br, input int rd,
                                     input int as, input int m2r, input int rw, input int mr,
                                     input int mw, input int aop);
    return {1'(ir), 1'(pc), 1'(br), 1'(rd), 1'(as), 1'(m2r), 1'(rw), 1'(mr), 1'(mw),
            3'(aop), 1'b1, 1'b0};
  endfunction

  // Entry and exit at a negedge with the FSM in FETCH.
  task automatic do_instr(input vec_t v);
    int cyc;
    chk("fetch_state", int'(state), 1);
    chk("fetch_ctl", int'(ctl), int'(mk(1,1,0,0,0,0,0,0,0,0)));
    op_code  = 4'(v.op);
    alu_zero = 1'(v.az);
    mem_ack  = 1'b0;
    cyc = 1;
    @(negedge clock); cyc++;
    chk("decode_state", int'(state), 2);
    chk("decode_ctl", int'(ctl), int'(mk(0,0,0,0,0,0,0,0,0,0)));
    @(negedge clock); cyc++;
    chk("exec_state", int'(state), 3);
    chk("exec_ctl", int'(ctl), int'(mk(0,0,v.br,0,v.asrc,0,0,0,0,v.aop)));
    op_code = ~4'(v.op);
    if (v.is_mem != 0) begin
      for (int k = 1; k <= v.ack; k++) begin
        @(negedge clock); cyc++;
        chk("mem_state", int'(state), 4);
        chk("mem_ctl", int'(ctl), int'(mk(0,0,0,0,0,0,0,v.mr,v.mw,0)));
        mem_ack = (k == v.ack);
      end
    end
    if (v.is_wb != 0) begin
      @(negedge clock); cyc++;
      mem_ack = 1'b0;
      chk("wb_state", int'(state), 5);
      chk("wb_ctl", int'(ctl), int'(mk(0,0,0,v.rdst,0,v.m2r,1,0,0,0)));
    end
    @(negedge clock);
    mem_ack = 1'b0;
    exp_ret++;
    chk("next_state", int'(state), 1);
    chk("latency", cyc, v.lat);
    chk("retired", int'(retired), exp_ret % 65536);
    chk("retired_w", int'(w_ret), exp_ret % 16);
    chk("mem_err", int'(mem_err), exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //          op az ack aop as br rd m2r mem wb mr mw lat
    vecs[0]  = '{0, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 0, 4};
    vecs[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4};
    vecs[2]  = '{2, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 4};
    vecs[3]  = '{3, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0, 4};
    vecs[4]  = '{4, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 4};
    vecs[5]  = '{5, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 3};
    vecs[6]  = '{6, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vecs[7]  = '{5, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vecs[8]  = '{6, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 3};
    vecs[9]  = '{7, 0, 3, 0, 1, 0, 0, 1, 1, 1, 1, 0, 7};
    vecs[10] = '{8, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 4};
    vecs[11] = '{7, 0, 15, 0, 1, 0, 0, 1, 1, 1, 1, 0, 19};
    vecs[12] = '{8, 1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 1, 5};

    reset_n = 1'b0; run = 1'b0; op_code = 4'd0; alu_zero = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_state", int'(state), 0);
    chk("rst_ctl", int'(ctl), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_mem_err", int'(mem_err), 0);

    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("idle_hold", int'(state), 0);
    run = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 13; i++) do_instr(vecs[i]);

    // sw with no ack: times out after 15 MEM cycles, not retired
    chk("to_fetch", int'(state), 1);
    op_code = 4'd8;
    @(negedge clock);
    @(negedge clock);
    chk("to_exec", int'(state), 3);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      chk("to_mem_ctl", int'(ctl), int'(mk(0,0,0,0,0,0,0,0,1,0)));
      chk("to_mem_err_pending", int'(mem_err), 0);
    end
    @(negedge clock);
    exp_err = 1;
    chk("to_state", int'(state), 1);
    chk("to_mem_err", int'(mem_err), 1);
    chk("to_strobe", int'(ctl), int'(mk(1,1,0,0,0,0,0,0,0,0)));
    chk("to_retired", int'(retired), exp_ret);

    // run dropped mid-branch takes effect only at the instruction boundary
    op_code = 4'd5; alu_zero = 1'b0;
    @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    chk("run0_exec", int'(state), 3);
    @(negedge clock);
    exp_ret++;
    chk("run0_idle", int'(state), 0);
    chk("run0_ctl", int'(ctl), 0);
    chk("run0_retired", int'(retired), exp_ret);
    @(negedge clock);
    chk("run0_stay", int'(state), 0);
    run = 1'b1;
    @(negedge clock);

    while (exp_ret < 17) begin
      do_instr(vecs[5]);
      if (exp_ret == 16) chk("wrap_w", int'(w_ret), 0);
    end

    // asynchronous reset in the middle of a store
    op_code = 4'd8;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("rstm_pre", int'(mem_write), 1);
    #1 reset_n = 1'b0;
    #1;
    exp_ret = 0; exp_err = 0;
    chk("rstm_mem_write", int'(mem_write), 0);
    chk("rstm_state", int'(state), 0);
    chk("rstm_retired", int'(retired), 0);
    chk("rstm_mem_err", int'(mem_err), 0);
    chk("rstm_ctl", int'(ctl), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rstm_restart", int'(state), 1);

    // illegal opcode 1100
    op_code = 4'hC;
    @(negedge clock);
    chk("ill_decode", int'(state), 2);
    @(negedge clock);
`ifdef MMC_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      chk("ill_trap_state", int'(state), 6);
      chk("ill_trap_ctl", int'(ctl), 3);
      chk("ill_trap_retired", int'(retired), 0);
      @(negedge clock);
    end
    reset_n = 1'b0;
    #1 chk("ill_trap_rst", int'(ctl), 0);
    reset_n = 1'b1;
`else
    chk("ill_nop_state", int'(state), 1);
    chk("ill_nop_retired", int'(retired), 1);
    chk("ill_nop_trap", int'(trap), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM-state cycles spent waiting for mem_ack.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports are clock and reset_n.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 run  input  1  level request to execute instructions.
REQ-007 op_code  input  4  instruction[15:12], sampled in DECODE.
REQ-008 alu_zero  input  1  ALU zero flag, sampled in EXEC.
REQ-009 mem_ack  input  1  data-memory completion strobe.
REQ-010 ir_write, pc_write, pc_branch  output  1 each  instruction-register load, PC+1 load, branch-target load.
REQ-011 reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write  output  1 each  datapath controls.
REQ-012 alu_op  output  3  ALU operation class.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mem_err  output  1  sticky memory-timeout flag.
REQ-015 trap  output  1  illegal-opcode indication.
REQ-016 state  output  3  encoding IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
REQ-017 retired  output  CNT_W  count of completed instructions.

Function
REQ-018 Opcode map SHALL be: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 slti, 0101 beq, 0110 bne, 0111 lw, 1000 sw; opcodes 1001-1111 are illegal.
REQ-019 alu_op SHALL be: R-type 111 (use func), addi/lw/sw 000, andi 001, ori 010, slti 011, beq/bne 100 (subtract).
REQ-020 IDLE->FETCH SHALL occur when run=1; otherwise the block stays in IDLE.
REQ-021 FETCH SHALL assert ir_write and pc_write for exactly one cycle, then go to DECODE.
REQ-022 DECODE SHALL latch op_code, go to EXEC for legal opcodes, and handle illegal opcodes per REQ-035/036.
REQ-023 EXEC SHALL drive alu_op and alu_src (1 for immediate, lw and sw); R-type and I-type go to WB, lw/sw go to MEM, beq/bne go to FETCH.
REQ-024 pc_branch SHALL pulse in EXEC when beq and alu_zero=1, or when bne and alu_zero=0.
REQ-025 MEM SHALL hold mem_read (lw) or mem_write (sw) high until mem_ack=1; lw then goes to WB, sw to FETCH.
REQ-026 If mem_ack has not arrived after MEM_TIMEOUT MEM cycles, the block SHALL set mem_err, drop the strobe, skip WB and go to FETCH.
REQ-027 mem_ack in the same cycle as the timeout SHALL count as success, with mem_err unchanged.
REQ-028 WB SHALL pulse reg_write for one cycle, with reg_dest=1 for R-type and mem_to_reg=1 for lw.
REQ-029 Latency SHALL be: R/I-type 4 cycles, beq/bne 3, sw 3+N, lw 4+N, where N≥1 is the MEM-state cycle count.
REQ-030 retired SHALL increment by 1 on leaving WB, on sw completion and on leaving EXEC for a branch; it wraps from all-ones to 0, and timed-out instructions are not counted.
REQ-031 Instead of entering FETCH, the block SHALL enter IDLE if run=0; run is otherwise ignored mid-instruction.
REQ-032 All datapath controls SHALL be 0 in states where they are not explicitly asserted.

Reset
REQ-033 reset_n=0 SHALL immediately force state=IDLE and set every output, retired and mem_err to 0, including mid-instruction, with no write strobe left asserted.
REQ-034 mem_err SHALL clear only on reset.

Configuration
REQ-035 With MMC_ILLEGAL_TRAP_EN defined, an illegal opcode in DECODE SHALL enter TRAP, assert trap, hold all strobes low and stay in TRAP until reset; retired is not incremented.
REQ-036 Without MMC_ILLEGAL_TRAP_EN, an illegal opcode SHALL behave as a NOP: DECODE goes to FETCH (or IDLE per REQ-031), retired increments, and trap is tied to 0.

Verification
REQ-037 Scenario: run=1, op_code=0000 -> states 1,2,3,5 and back to 1; reg_write=1 with reg_dest=1 in WB; alu_op=111; retired=1.
REQ-038 Scenario: lw (0111) with mem_ack on the 3rd MEM cycle -> mem_read high for 3 cycles, mem_to_reg=1 in WB, total 7 cycles.
REQ-039 Scenario: beq with alu_zero=1, then bne with alu_zero=1 -> pc_branch pulses once (beq only); retired=2.
REQ-040 Scenario: sw with mem_ack never asserted -> after 15 MEM cycles mem_err=1 and mem_write=0, the next state is FETCH, and retired is unchanged.
REQ-041 Scenario: opcode 1100 -> trap=1 in state 6 with the macro defined; without it, a NOP and retired increments.
REQ-042 Scenario: reset_n low in MEM during sw -> mem_write=0 combinationally, state=0, retired=0; with retired preset to 0xFFFF, one more instruction wraps it to 0x0000.
